// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run-control sequencer for the single-cycle schoolMIPS core.
// Drives cpu_en (retire enable) for free-run, halt and N-instruction step,
// and keeps a retired-instruction counter.
// Optional PC breakpoint: define SM_BREAKPOINT_EN to compile it in.
module sm_run_ctrl #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned STEP_W    = 8,
   parameter bit          RESET_RUN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_req,
   input  logic              halt_req,
   input  logic              step_req,
   input  logic [STEP_W-1:0] step_num,
   input  logic              cnt_clr,
   input  logic [31:0]       pc,
   input  logic [31:0]       bp_addr,
   input  logic              bp_valid,
   output logic              cpu_en,
   output logic              halted,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {
      ST_HALT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10,
      ST_BREAK = 2'b11
   } state_e;

   localparam state_e RST_STATE = RESET_RUN ? ST_RUN : ST_HALT;

   state_e              state_q,   state_d;
   logic [STEP_W-1:0]   remain_q,  remain_d;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic                active_c;
   logic                bp_block_c;

`ifdef SM_BREAKPOINT_EN
   logic                skip_q,    skip_d;

   // Hold off retirement at an armed breakpoint unless resuming from it
   assign bp_block_c = bp_valid & (pc == bp_addr) & ~skip_q;
`else
   logic                unused_bp;

   // Breakpoint inputs are not used in this build
   assign unused_bp  = ^{pc, bp_addr, bp_valid};
   assign bp_block_c = 1'b0;
`endif

   // Retire enable: active states only, unless blocked by a breakpoint
   assign active_c = (state_q == ST_RUN) | (state_q == ST_STEP);
   assign cpu_en   = active_c & ~bp_block_c;

   assign halted   = (state_q == ST_HALT) | (state_q == ST_BREAK);
   assign state    = state_q;
   assign retired  = retired_q;

   // Next-state, step countdown and retired counter
   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
`ifdef SM_BREAKPOINT_EN
      skip_d    = skip_q;
      if (cpu_en) begin
         skip_d = 1'b0;
      end
`endif
      case (state_q)
         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (bp_block_c) begin
               state_d = ST_BREAK;
            end
         end
         ST_STEP: begin
            if (halt_req) begin
               state_d  = ST_HALT;
               remain_d = '0;
            end else if (bp_block_c) begin
               state_d  = ST_BREAK;
               remain_d = '0;
            end else if (remain_q == STEP_W'(1)) begin
               state_d  = ST_HALT;
               remain_d = '0;
            end else begin
               remain_d = remain_q - STEP_W'(1);
            end
         end
         default: begin
            // HALT and BREAK: halt_req has no effect and blocks other commands
            if (!halt_req) begin
               if (step_req) begin
                  state_d  = ST_STEP;
                  remain_d = (step_num == '0) ? STEP_W'(1) : step_num;
`ifdef SM_BREAKPOINT_EN
                  skip_d   = 1'b1;
`endif
               end else if (run_req) begin
                  state_d  = ST_RUN;
`ifdef SM_BREAKPOINT_EN
                  skip_d   = 1'b1;
`endif
               end
            end
         end
      endcase

      if (cnt_clr) begin
         retired_d = '0;
      end else begin
         retired_d = retired_q + CNT_W'(cpu_en);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RST_STATE;
         remain_q  <= '0;
         retired_q <= '0;
`ifdef SM_BREAKPOINT_EN
         skip_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         retired_q <= retired_d;
`ifdef SM_BREAKPOINT_EN
         skip_q    <= skip_d;
`endif
      end
   end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Testbench for sm_run_ctrl: directed commands, per-cycle reference model,
// plus literal expectations at key points. Breakpoint scenario runs only
// when SM_BREAKPOINT_EN is defined.
module tb_sm_run_ctrl;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned STEP_W = 8;
`ifdef SM_BREAKPOINT_EN
   localparam bit BP_ON = 1'b1;
`else
   localparam bit BP_ON = 1'b0;
`endif

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              run_req  = 1'b0;
   logic              halt_req = 1'b0;
   logic              step_req = 1'b0;
   logic [STEP_W-1:0] step_num = '0;
   logic              cnt_clr  = 1'b0;
   logic [31:0]       pc       = '0;
   logic [31:0]       bp_addr  = '0;
   logic              bp_valid = 1'b0;
   logic              cpu_en;
   logic              halted;
   logic [1:0]        state;
   logic [CNT_W-1:0]  retired;

   int n_tests = 0;
   int n_fail  = 0;

   sm_run_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W), .RESET_RUN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .step_num(step_num), .cnt_clr(cnt_clr),
      .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
      .cpu_en(cpu_en), .halted(halted), .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 halt, 1 run, 2 step, 3 break
   int m_mode = 1;
   int m_left = 0;
   int m_ret  = 0;
   bit m_skip = 1'b0;
   bit m_hit, m_act, m_en;

   always @(negedge clk) begin : model
      if (!rst_n) begin
         m_mode = 1;
         m_left = 0;
         m_ret  = 0;
         m_skip = 1'b0;
      end
      m_hit = BP_ON && bp_valid && (pc == bp_addr) && !m_skip;
      m_act = (m_mode == 1) || (m_mode == 2);
      m_en  = m_act && !m_hit;
      chk("cyc_cpu_en",  32'(cpu_en),  32'(m_en));
      chk("cyc_state",   32'(state),   m_mode);
      chk("cyc_halted",  32'(halted),  32'((m_mode == 0) || (m_mode == 3)));
      chk("cyc_retired", 32'(retired), m_ret);
      if (rst_n) begin
         if (m_act) begin
            if (halt_req) begin
               m_mode = 0; m_left = 0;
            end else if (m_hit) begin
               m_mode = 3; m_left = 0;
            end else if (m_mode == 2) begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = 0;
            end
         end else if (!halt_req) begin
            if (step_req) begin
               m_mode = 2;
               m_left = (step_num == 0) ? 1 : int'(step_num);
               m_skip = 1'b1;
            end else if (run_req) begin
               m_mode = 1;
               m_skip = 1'b1;
            end
         end
         if (m_en) m_skip = 1'b0;
         m_ret = cnt_clr ? 0 : (m_ret + (m_en ? 1 : 0)) % 16;
      end
   end

   // One cycle: the core advances its PC whenever the cycle retired
   task automatic step_clk();
      logic en_prev;
      @(negedge clk);
      en_prev = cpu_en;
      @(posedge clk);
      #1;
      run_req  = 1'b0;
      halt_req = 1'b0;
      step_req = 1'b0;
      cnt_clr  = 1'b0;
      if (en_prev) pc = pc + 32'd1;
   endtask

   task automatic lit(input string name, input logic [31:0] act_now, input logic [31:0] exp);
      chk(name, act_now, exp);
   endtask

   int cnt;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      lit("rst_state",   32'(state),   32'd1);
      lit("rst_retired", 32'(retired), 32'd0);

      // Free run for 10 cycles
      repeat (10) step_clk();
      #1;
      lit("run10_retired", 32'(retired), 32'd10);
      lit("run10_state",   32'(state),   32'd1);

      // Halt: the request cycle still retires
      halt_req = 1'b1;
      step_clk();
      #1;
      lit("halt_state",   32'(state),   32'd0);
      lit("halt_retired", 32'(retired), 32'd11);
      lit("halt_cpu_en",  32'(cpu_en),  32'd0);
      repeat (2) step_clk();
      #1;
      lit("halt_hold_retired", 32'(retired), 32'd11);

      // Step 3
      step_num = 8'd3; step_req = 1'b1;
      cnt = 0;
      repeat (6) begin step_clk(); #1; if (cpu_en) cnt++; end
      lit("step3_count",   32'(cnt),     32'd3);
      lit("step3_state",   32'(state),   32'd0);
      lit("step3_retired", 32'(retired), 32'd14);

      // Step 0 behaves as step 1
      step_num = 8'd0; step_req = 1'b1;
      cnt = 0;
      repeat (4) begin step_clk(); #1; if (cpu_en) cnt++; end
      lit("step0_count",   32'(cnt),     32'd1);
      lit("step0_retired", 32'(retired), 32'd15);

      // Step 5 cut short by halt in the 2nd enabled cycle (counter wraps 17 -> 1)
      step_num = 8'd5; step_req = 1'b1;
      step_clk();
      step_clk();
      halt_req = 1'b1;
      step_clk();
      #1;
      lit("step5h_state",   32'(state),   32'd0);
      lit("step5h_retired", 32'(retired), 32'd1);
      repeat (3) step_clk();
      #1;
      lit("step5h_hold", 32'(retired), 32'd1);

      // Simultaneous halt + step in HALT: stays halted
      halt_req = 1'b1; step_req = 1'b1; step_num = 8'd4;
      step_clk();
      #1;
      lit("halt_step_state", 32'(state), 32'd0);
      step_clk();
      #1;
      lit("halt_step_retired", 32'(retired), 32'd1);

      // cnt_clr wins over increment, then 16-cycle wrap
      run_req = 1'b1;
      step_clk();
      step_clk();
      #1;
      lit("clr_pre", 32'(retired), 32'd2);
      cnt_clr = 1'b1;
      step_clk();
      #1;
      lit("clr_retired", 32'(retired), 32'd0);
      repeat (8) step_clk();
      #1;
      lit("wrap_mid", 32'(retired), 32'd8);
      repeat (8) step_clk();
      #1;
      lit("wrap_zero", 32'(retired), 32'd0);
      halt_req = 1'b1;
      step_clk();
      #1;
      lit("wrap_halt", 32'(retired), 32'd1);

      // Reset in the middle of a step sequence
      step_num = 8'd5; step_req = 1'b1;
      step_clk();
      step_clk();
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      lit("rst_mid_state",   32'(state),   32'd1);
      lit("rst_mid_retired", 32'(retired), 32'd0);
      halt_req = 1'b1;
      step_clk();

`ifdef SM_BREAKPOINT_EN
      // Breakpoint at 8 from pc 0
      pc = 32'd0; bp_addr = 32'd8; bp_valid = 1'b1;
      run_req = 1'b1;
      step_clk();
      for (int i = 0; i < 20 && state != 2'b11; i++) step_clk();
      #1;
      lit("bp_state",  32'(state),  32'd3);
      lit("bp_pc",     pc,          32'd8);
      lit("bp_cpu_en", 32'(cpu_en), 32'd0);
      lit("bp_halted", 32'(halted), 32'd1);
      // Resume: instruction at 8 retires once
      run_req = 1'b1;
      step_clk();
      #1;
      lit("bp_resume_en", 32'(cpu_en), 32'd1);
      step_clk();
      #1;
      lit("bp_past_pc",    pc,          32'd9);
      lit("bp_past_state", 32'(state),  32'd1);
      halt_req = 1'b1;
      step_clk();
      // Returning to 8 breaks again
      pc = 32'd6;
      run_req = 1'b1;
      step_clk();
      for (int i = 0; i < 10 && state != 2'b11; i++) step_clk();
      #1;
      lit("bp_again_state", 32'(state), 32'd3);
      lit("bp_again_pc",    pc,         32'd8);
      // halt_req coinciding with a match goes to HALT, not BREAK
      pc = 32'd7;
      run_req = 1'b1;
      step_clk();
      step_clk();
      #1;
      lit("bp_halt_pc", pc, 32'd8);
      halt_req = 1'b1;
      step_clk();
      #1;
      lit("bp_halt_state", 32'(state), 32'd0);
      bp_valid = 1'b0;
`endif

      repeat (2) step_clk();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sm_run_ctrl.md
Name: sm_run_ctrl

Overview:
Run-control sequencer for the single-cycle schoolMIPS core. It decides in which cycles the core may retire an instruction by driving cpu_en, which gates the PC register update and the register-file write enable. It supports free-run, halt and N-instruction step, and keeps a retired-instruction counter. Commands come from the debug/board-control logic; the current PC is taken from the core.

Parameters:
CNT_W, 32, width of the retired-instruction counter
STEP_W, 8, width of the step-count input
RESET_RUN, 1, state after reset: 1 = RUN, 0 = HALT

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
run_req  in  1  pulse: enter free run
halt_req  in  1  pulse: stop retiring
step_req  in  1  pulse: retire step_num instructions, then halt
step_num  in  STEP_W  step length; 0 is treated as 1
cnt_clr  in  1  synchronous clear of retired
pc  in  32  current core PC (word address)
bp_addr  in  32  breakpoint address (optional feature only)
bp_valid  in  1  breakpoint armed (optional feature only)
cpu_en  out  1  core retire enable for this cycle
halted  out  1  1 in HALT or BREAK
state  out  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK
retired  out  CNT_W  count of cycles with cpu_en=1

Behaviour:
- Clocking and reset: one clock domain. rst_n is asynchronous and active-low.
- Reset values:
  - state = RUN if RESET_RUN=1, else HALT
  - retired = 0, step counter remain = 0, skip flag = 0
  - halted follows state
- cpu_en = (state==RUN | state==STEP) & ~bp_block. bp_block is always 0 when the feature is off.
- Command priority within one cycle: halt_req > step_req > run_req.
- HALT:
  - step_req -> STEP, remain = (step_num==0 ? 1 : step_num).
  - run_req -> RUN.
  - halt_req -> no effect.
- RUN:
  - halt_req -> HALT. The current cycle still retires (cpu_en=1), so there is 1-cycle halt latency.
  - run_req and step_req are ignored.
- STEP:
  - remain decrements in each cycle with cpu_en=1.
  - remain==1 with cpu_en=1 -> HALT.
  - halt_req -> HALT. The current cycle retires; remaining steps are discarded.
  - run_req and step_req are ignored.
- Step timing: after step_req in HALT, cpu_en is high for exactly N consecutive cycles, starting the cycle after the request.
- retired counter:
  - Increments by 1 in each cycle with cpu_en=1 and wraps modulo 2^CNT_W.
  - cnt_clr wins over a simultaneous increment (result 0).
- Reset mid-STEP: returns to the reset state, remain = 0, retired = 0.
- pc is unused when the feature is compiled out.
- state 11 is unreachable when the feature is compiled out.

Optional Feature:
Macro SM_BREAKPOINT_EN.
- With the macro:
  - match = bp_valid & (pc==bp_addr).
  - bp_block = match & ~skip. The instruction at bp_addr does not retire in that cycle, and state -> BREAK next cycle.
  - BREAK behaves like HALT, including step_req and run_req handling.
  - Leaving HALT or BREAK via run_req or step_req sets skip=1. skip clears after the first cycle with cpu_en=1, so resuming at the breakpoint PC executes it once.
  - halt_req in the same cycle as a match: state -> HALT, not BREAK.
- Without the macro:
  - bp_addr and bp_valid are ignored, and skip logic is absent.
  - cpu_en depends only on state.

Test Plan:
- Reset with RESET_RUN=1, no commands for 10 cycles -> state=01, cpu_en=1 every cycle, retired=10.
- RUN, halt_req pulse at cycle k -> cpu_en=1 at k, 0 from k+1; state=00; retired stops incrementing.
- HALT, step_req with step_num=3 -> cpu_en high exactly 3 cycles, then state=00, retired +3. Repeat with step_num=0 -> exactly 1 cycle.
- STEP with step_num=5, halt_req in the 2nd enabled cycle -> 2 retirements total, state=00. Same-cycle halt_req+step_req in HALT -> stays HALT.
- cnt_clr asserted together with a retiring cycle -> retired=0. Run 2^CNT_W cycles at CNT_W=4 -> retired wraps to 0.
- SM_BREAKPOINT_EN, bp_valid=1, bp_addr=0x8, RUN from pc 0 -> cpu_en=0 while pc=8, state=11. Then run_req -> instruction at 8 retires and no re-break at 8 until pc leaves and returns.
